pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RV32 core. It merges per-stage stall requests into `ctrl_stall[4:0]` and sequences trap entry and `mret` through a small FSM. During those sequences it drives `ctrl_flush`, the multi-cycle machine-CSR update writes, and the PC redirect. It sits beside the pipeline registers (`if_id` … `mem_wb`), and its outputs fan out to all of them.

---
 rtl/pipe_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge and trap/mret sequencing FSM for the 5-stage RV32 core
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   stallreq_if/id/ex/mem      per-stage stall requests
//   mem_valid, mem_pc          MEM-stage instruction valid and its PC
//   exc_valid, exc_cause       synchronous exception from MEM
//   mret_valid                 MEM-stage instruction is mret
//   irq_ext, irq_timer         level interrupt lines
//   csr_mstatus/mie/mtvec/mepc live machine CSR values
//   ctrl_stall[4:0]            stall: pc, if_id, id_ex, ex_mem, mem_wb
//   ctrl_flush                 bubble all pipeline registers
//   redirect_valid/_pc         PC load
//   csr_we/_waddr/_wdata       trap-sequence CSR write port
//   trap_busy                  FSM not idle
module pipe_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_pc,
    input  logic             exc_valid,
    input  logic [3:0]       exc_cause,
    input  logic             mret_valid,
    input  logic             irq_ext,
    input  logic             irq_timer,
    input  logic [WIDTH-1:0] csr_mstatus,
    input  logic [WIDTH-1:0] csr_mie,
    input  logic [WIDTH-1:0] csr_mtvec,
    input  logic [WIDTH-1:0] csr_mepc,
    output logic [4:0]       ctrl_stall,
    output logic             ctrl_flush,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             csr_we,
    output logic [11:0]      csr_waddr,
    output logic [WIDTH-1:0] csr_wdata,
    output logic             trap_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_MEPC,
        S_T_MCAUSE,
        S_T_MSTATUS,
        S_T_JUMP,
        S_R_MSTATUS,
        S_R_JUMP
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] cause_q, cause_d;
    logic             is_irq_q, is_irq_d;

    logic             any_stall;
    logic [4:0]       stall_merge;
    logic             irq_ext_pend;
    logic             irq_tmr_pend;
    logic             irq_take;
    logic [WIDTH-1:0] irq_cause;
    logic             trap_take;
    logic             mret_take;
    logic [WIDTH-1:0] mstatus_trap;
    logic [WIDTH-1:0] mstatus_mret;
    logic [WIDTH-1:0] vec_base;
    logic [WIDTH-1:0] vec_off;
    logic             unused_mie;

    assign unused_mie = ^{csr_mie[WIDTH-1:12], csr_mie[10:8], csr_mie[6:0]};

    // Request decode and next-state logic
    always_comb begin
        any_stall = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

        // The deepest stalled stage freezes itself and everything upstream.
        if (stallreq_mem)     stall_merge = 5'b11111;
        else if (stallreq_ex) stall_merge = 5'b01111;
        else if (stallreq_id) stall_merge = 5'b00111;
        else if (stallreq_if) stall_merge = 5'b00011;
        else                  stall_merge = 5'b00000;

        irq_ext_pend = csr_mstatus[3] & irq_ext & csr_mie[11];
        irq_tmr_pend = csr_mstatus[3] & irq_timer & csr_mie[7];
        // Only interrupt a real, non-stalled MEM instruction so mepc is exact.
        irq_take  = (irq_ext_pend | irq_tmr_pend) & mem_valid & ~any_stall;
        irq_cause = irq_ext_pend ? WIDTH'(32'h8000000B) : WIDTH'(32'h80000007);

        trap_take = (state_q == S_IDLE) & (exc_valid | irq_take);
        mret_take = (state_q == S_IDLE) & ~exc_valid & ~irq_take & mret_valid;

        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        is_irq_d = is_irq_q;

        case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    state_d  = S_T_MEPC;
                    epc_d    = mem_pc;
                    cause_d  = {{(WIDTH-4){1'b0}}, exc_cause};
                    is_irq_d = 1'b0;
                end else if (irq_take) begin
                    state_d  = S_T_MEPC;
                    epc_d    = mem_pc;
                    cause_d  = irq_cause;
                    is_irq_d = 1'b1;
                end else if (mret_valid) begin
                    state_d = S_R_MSTATUS;
                end
            end
            S_T_MEPC:    state_d = S_T_MCAUSE;
            S_T_MCAUSE:  state_d = S_T_MSTATUS;
            S_T_MSTATUS: state_d = S_T_JUMP;
            S_T_JUMP:    state_d = S_IDLE;
            S_R_MSTATUS: state_d = S_R_JUMP;
            S_R_JUMP:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode: IDLE is request-driven, other states depend on state_q
    // plus the live CSR values they rewrite or jump to.
    always_comb begin
        mstatus_trap         = csr_mstatus;
        mstatus_trap[7]      = csr_mstatus[3];
        mstatus_trap[3]      = 1'b0;
        mstatus_trap[12:11]  = 2'b11;

        mstatus_mret         = csr_mstatus;
        mstatus_mret[3]      = csr_mstatus[7];
        mstatus_mret[7]      = 1'b1;
        mstatus_mret[12:11]  = 2'b11;

        vec_base = {csr_mtvec[WIDTH-1:2], 2'b00};
        vec_off  = {{(WIDTH-6){1'b0}}, cause_q[3:0], 2'b00};

        ctrl_stall     = 5'b00000;
        ctrl_flush     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_we         = 1'b0;
        csr_waddr      = 12'h000;
        csr_wdata      = '0;
        trap_busy      = 1'b0;

        // Holding reset silences everything, including a half-done CSR sequence.
        if (rst_n) begin
            if (state_q == S_IDLE) begin
                if (trap_take | mret_take) begin
                    ctrl_stall = 5'b11111;
                    ctrl_flush = 1'b1;
                end else begin
                    ctrl_stall = stall_merge;
                end
            end else begin
                ctrl_stall = 5'b11111;
                ctrl_flush = 1'b1;
                trap_busy  = 1'b1;
            end

            case (state_q)
                S_T_MEPC: begin
                    csr_we    = 1'b1;
                    csr_waddr = ADDR_MEPC;
                    csr_wdata = epc_q;
                end
                S_T_MCAUSE: begin
                    csr_we    = 1'b1;
                    csr_waddr = ADDR_MCAUSE;
                    csr_wdata = cause_q;
                end
                S_T_MSTATUS: begin
                    csr_we    = 1'b1;
                    csr_waddr = ADDR_MSTATUS;
                    csr_wdata = mstatus_trap;
                end
                S_T_JUMP: begin
                    redirect_valid = 1'b1;
                    if (csr_mtvec[1:0] == 2'b01 && is_irq_q) begin
                        redirect_pc = vec_base + vec_off;
                    end else begin
                        redirect_pc = vec_base;
                    end
                end
                S_R_MSTATUS: begin
                    csr_we    = 1'b1;
                    csr_waddr = ADDR_MSTATUS;
                    csr_wdata = mstatus_mret;
                end
                S_R_JUMP: begin
                    redirect_valid = 1'b1;
                    redirect_pc    = csr_mepc;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            epc_q    <= '0;
            cause_q  <= '0;
            is_irq_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            is_irq_q <= is_irq_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic        mret_valid;
    logic        irq_ext, irq_timer;
    logic [31:0] csr_mstatus, csr_mie, csr_mtvec, csr_mepc;
    logic [4:0]  ctrl_stall;
    logic        ctrl_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        trap_busy;

    pipe_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .mem_valid(mem_valid), .mem_pc(mem_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause),
        .mret_valid(mret_valid), .irq_ext(irq_ext), .irq_timer(irq_timer),
        .csr_mstatus(csr_mstatus), .csr_mie(csr_mie),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
        .ctrl_stall(ctrl_stall), .ctrl_flush(ctrl_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .trap_busy(trap_busy)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // kind 0 = CSR write, kind 1 = redirect
    typedef struct packed {
        logic        kind;
        logic [31:0] at;
        logic [11:0] addr;
        logic [31:0] data;
    } evt_t;

    evt_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input logic k, input int off, input logic [11:0] a, input logic [31:0] d);
        evt_t e;
        e.kind = k;
        e.at   = cyc + 32'(off);
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input logic k, input logic [11:0] a, input logic [31:0] d);
        evt_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_evt: got kind=%0d addr=%h data=%h at cyc %0d required none",
                     k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.at !== cyc || e.addr !== a || e.data !== d) begin
                n_err++;
                $display("FAIL evt: got kind=%0d cyc=%0d addr=%h data=%h required kind=%0d cyc=%0d addr=%h data=%h",
                         k, cyc, a, d, e.kind, e.at, e.addr, e.data);
            end
        end
    endtask

    // Monitor: every CSR write and redirect must match the next queued expectation.
    always @(negedge clk) begin
        if (csr_we === 1'b1) mon_check(1'b0, csr_waddr, csr_wdata);
        if (redirect_valid === 1'b1) mon_check(1'b1, 12'h000, redirect_pc);
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_stall"}, {27'd0, ctrl_stall}, 32'd0);
        chk({nm, "_flush"}, {31'd0, ctrl_flush}, 32'd0);
        chk({nm, "_redir"}, {31'd0, redirect_valid}, 32'd0);
        chk({nm, "_redir_pc"}, redirect_pc, 32'd0);
        chk({nm, "_we"}, {31'd0, csr_we}, 32'd0);
        chk({nm, "_waddr"}, {20'd0, csr_waddr}, 32'd0);
        chk({nm, "_wdata"}, csr_wdata, 32'd0);
        chk({nm, "_busy"}, {31'd0, trap_busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        mem_valid = 0; mem_pc = 0; exc_valid = 0; exc_cause = 0; mret_valid = 0;
        irq_ext = 0; irq_timer = 0;
        csr_mstatus = 0; csr_mie = 0; csr_mtvec = 0; csr_mepc = 0;

        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk_all_zero("idle");

        // Stall merge
        stallreq_id = 1; #1;
        chk("stall_id", {27'd0, ctrl_stall}, 32'h07);
        stallreq_mem = 1; #1;
        chk("stall_id_mem", {27'd0, ctrl_stall}, 32'h1F);
        chk("stall_id_mem_flush", {31'd0, ctrl_flush}, 32'd0);
        tick();
        stallreq_id = 0; stallreq_mem = 0; stallreq_ex = 1; #1;
        chk("stall_ex", {27'd0, ctrl_stall}, 32'h0F);
        stallreq_ex = 0; stallreq_if = 1; #1;
        chk("stall_if", {27'd0, ctrl_stall}, 32'h03);
        stallreq_if = 0; #1;
        chk("stall_none", {27'd0, ctrl_stall}, 32'h00);
        chk("stall_none_flush", {31'd0, ctrl_flush}, 32'd0);
        chk("stall_busy", {31'd0, trap_busy}, 32'd0);

        // Exception together with stallreq_mem: exception wins
        tick();
        csr_mtvec = 32'h100; csr_mstatus = 32'h8; mem_pc = 32'h80; mem_valid = 1;
        exc_cause = 4'd2; exc_valid = 1; stallreq_mem = 1; #1;
        chk("exc_flush_T", {31'd0, ctrl_flush}, 32'd1);
        chk("exc_stall_T", {27'd0, ctrl_stall}, 32'h1F);
        push(1'b0, 1, 12'h341, 32'h80);
        push(1'b0, 2, 12'h342, 32'h2);
        push(1'b0, 3, 12'h300, 32'h1880);
        push(1'b1, 4, 12'h000, 32'h100);
        tick();
        exc_valid = 0; stallreq_mem = 0; #1;
        chk("exc_busy_T1", {31'd0, trap_busy}, 32'd1);
        repeat (4) tick();
        chk("exc_idle_T5_busy", {31'd0, trap_busy}, 32'd0);
        chk("exc_idle_T5_flush", {31'd0, ctrl_flush}, 32'd0);

        // Vectored timer interrupt
        csr_mtvec = 32'h201; csr_mstatus = 32'h8; csr_mie = 32'h80;
        mem_pc = 32'h200; irq_timer = 1; #1;
        chk("tmr_flush_T", {31'd0, ctrl_flush}, 32'd1);
        push(1'b0, 1, 12'h341, 32'h200);
        push(1'b0, 2, 12'h342, 32'h80000007);
        push(1'b0, 3, 12'h300, 32'h1880);
        push(1'b1, 4, 12'h000, 32'h21C);
        tick();
        irq_timer = 0;
        repeat (4) tick();
        chk("tmr_idle_T5", {31'd0, trap_busy}, 32'd0);

        // Interrupt masking by mstatus.MIE and by an active stall
        csr_mtvec = 32'h100; csr_mstatus = 32'h0; csr_mie = 32'h800;
        mem_pc = 32'h300; irq_ext = 1; #1;
        chk("mask_mie_flush", {31'd0, ctrl_flush}, 32'd0);
        tick();
        chk("mask_mie_busy", {31'd0, trap_busy}, 32'd0);
        csr_mstatus = 32'h8; stallreq_ex = 1; #1;
        chk("mask_stall_flush", {31'd0, ctrl_flush}, 32'd0);
        chk("mask_stall_vec", {27'd0, ctrl_stall}, 32'h0F);
        tick();
        chk("mask_stall_busy", {31'd0, trap_busy}, 32'd0);
        stallreq_ex = 0; #1;
        chk("ext_flush_T", {31'd0, ctrl_flush}, 32'd1);
        push(1'b0, 1, 12'h341, 32'h300);
        push(1'b0, 2, 12'h342, 32'h8000000B);
        push(1'b0, 3, 12'h300, 32'h1880);
        push(1'b1, 4, 12'h000, 32'h100);
        tick();
        irq_ext = 0;
        repeat (4) tick();
        chk("ext_idle_T5", {31'd0, trap_busy}, 32'd0);

        // mret
        csr_mstatus = 32'h1880; csr_mepc = 32'h84; csr_mie = 32'h0; mret_valid = 1; #1;
        chk("mret_flush_T", {31'd0, ctrl_flush}, 32'd1);
        push(1'b0, 1, 12'h300, 32'h1888);
        push(1'b1, 2, 12'h000, 32'h84);
        tick();
        mret_valid = 0; #1;
        chk("mret_busy_T1", {31'd0, trap_busy}, 32'd1);
        repeat (2) tick();
        chk("mret_idle_T3", {31'd0, trap_busy}, 32'd0);

        // Interrupt beats a pending mret
        csr_mstatus = 32'h8; csr_mie = 32'h80; csr_mtvec = 32'h100; mem_pc = 32'h90;
        irq_timer = 1; mret_valid = 1; #1;
        push(1'b0, 1, 12'h341, 32'h90);
        push(1'b0, 2, 12'h342, 32'h80000007);
        push(1'b0, 3, 12'h300, 32'h1880);
        push(1'b1, 4, 12'h000, 32'h100);
        tick();
        irq_timer = 0; mret_valid = 0;
        repeat (4) tick();
        chk("irq_mret_idle", {31'd0, trap_busy}, 32'd0);

        // Reset in the middle of a trap sequence
        exc_valid = 1; exc_cause = 4'd5; mem_pc = 32'h40; #1;
        push(1'b0, 1, 12'h341, 32'h40);
        tick();
        exc_valid = 0;
        tick();
        rst_n = 0; #1;
        chk_all_zero("rst_mid");
        tick();
        rst_n = 1; #1;
        chk_all_zero("rst_release");
        repeat (3) begin
            tick();
            chk("rst_after_busy", {31'd0, trap_busy}, 32'd0);
        end

        tick();
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
